// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter on the PicoRV32 native bus: byte FIFO, baud divider, 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
  parameter logic [7:0]  ADDR_HI     = 8'h02,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic          mem_ready_q;
  logic [31:0]   mem_rdata_q;
  logic [15:0]   clkdiv_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  state_e        state_q;
  logic [15:0]   cnt_q, div_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q, busy_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic        sel, is_wr, fifo_full, fifo_empty, accept, push, pop, bit_end;
  logic [1:0]  off;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[23:4], mem_addr[1:0], mem_wdata[31:16]};

  always_comb begin
    sel        = mem_valid && (mem_addr[31:24] == ADDR_HI) && !mem_ready_q;
    is_wr      = |mem_wstrb;
    off        = mem_addr[3:2];
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    // A DATA write into a full FIFO is held off until the serializer frees a slot.
    accept     = sel && !(is_wr && (off == 2'd0) && fifo_full);
    push       = accept && is_wr && (off == 2'd0);
    bit_end    = (cnt_q == 16'd0);
    pop        = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    rd_val     = '0;
    case (off)
      2'd1:    rd_val = {16'b0, 8'(count_q), 5'b0, busy_q, fifo_empty, fifo_full};
      2'd2:    rd_val = {16'b0, clkdiv_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      clkdiv_q    <= DEFAULT_DIV;
    end else begin
      mem_ready_q <= accept;
      mem_rdata_q <= (accept && !is_wr) ? rd_val : '0;
      if (accept && is_wr && (off == 2'd2)) begin
        clkdiv_q <= (mem_wdata[15:0] < 16'd2) ? 16'd2 : mem_wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // txd_q is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      busy_q <= !fifo_empty || (state_q != StIdle);
      case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_q[rptr_q];
            div_q   <= clkdiv_q;
            cnt_q   <= clkdiv_q - 16'd1;
            state_q <= StStart;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo_q[rptr_q];
`endif
          end
        end
        StStart: begin
          txd_q <= 1'b0;
          if (bit_end) begin
            cnt_q     <= div_q - 16'd1;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StData: begin
          txd_q <= shift_q[0];
          if (bit_end) begin
            cnt_q   <= div_q - 16'd1;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          txd_q <= parity_q;
          if (bit_end) begin
            cnt_q   <= div_q - 16'd1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`endif
        StStop: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            // Back-to-back frames: reload straight into START with no idle gap.
            if (pop) begin
              shift_q <= fifo_q[rptr_q];
              div_q   <= clkdiv_q;
              cnt_q   <= clkdiv_q - 16'd1;
              state_q <= StStart;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^fifo_q[rptr_q];
`endif
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign uart_txd  = txd_q;
  assign tx_busy   = busy_q;

endmodule
